// File: rtl/orion_types_pkg.sv
// Shared types for the MEM stage: EX->MEM / MEM->WB records, memory op codes and FSM states.
package orion_types;

    localparam int XLEN  = 32;
    localparam int ADDRW = 32;
    localparam int MASKW = XLEN / 8;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} mem_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
    } dbg_t;

    typedef struct packed {
        logic            valid;
        mem_op_e         op;
        logic [4:0]      rd_s;
        logic            rd_we;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] store_data;
        dbg_t            debug;
    } ex_mem_t;

    typedef struct packed {
        logic             valid;
        logic [4:0]       rd_s;
        logic             rd_we;
        logic [XLEN-1:0]  rd_v;
        logic [XLEN-1:0]  pc;
        logic [31:0]      insn;
        logic [ADDRW-1:0] mem_addr;
        logic [MASKW-1:0] mem_rmask;
        logic [MASKW-1:0] mem_wmask;
        logic [XLEN-1:0]  mem_rdata;
        logic [XLEN-1:0]  mem_wdata;
    } mem_wb_t;

    function automatic logic is_load(mem_op_e op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(mem_op_e op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic for the MEM stage: store replication/masks, load extraction and
// sign/zero extension, and natural-alignment checking. Purely combinational.
module mem_align
    import orion_types::*;
(
    input  mem_op_e          op,
    input  logic [1:0]       off,
    input  logic [XLEN-1:0]  store_data,
    input  logic [XLEN-1:0]  rdata,
    output logic             misaligned,
    output logic [MASKW-1:0] wmask,
    output logic [MASKW-1:0] rmask,
    output logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        misaligned = 1'b0;
        wmask      = '0;
        rmask      = '0;
        wdata      = store_data;
        load_val   = rdata;
        unique case (op)
            MEM_LB, MEM_LBU: begin
                rmask    = MASKW'(1) << off;
                load_val = (op == MEM_LB) ? {{(XLEN-8){byte_sel[7]}}, byte_sel}
                                          : {{(XLEN-8){1'b0}}, byte_sel};
            end
            MEM_LH, MEM_LHU: begin
                misaligned = off[0];
                rmask      = MASKW'(3) << off;
                load_val   = (op == MEM_LH) ? {{(XLEN-16){half_sel[15]}}, half_sel}
                                            : {{(XLEN-16){1'b0}}, half_sel};
            end
            MEM_LW: begin
                misaligned = (off != 2'd0);
                rmask      = '1;
            end
            MEM_SB: begin
                wdata = {(XLEN/8){store_data[7:0]}};
                wmask = MASKW'(1) << off;
            end
            MEM_SH: begin
                misaligned = off[0];
                wdata      = {(XLEN/16){store_data[15:0]}};
                wmask      = MASKW'(3) << off;
            end
            MEM_SW: begin
                misaligned = (off != 2'd0);
                wmask      = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory requests, stalls EX while an access is
// outstanding and produces the registered MEM->WB record.
//
//  state   | meaning
//  IDLE    | no access outstanding; new ops requested combinationally from ex_mem_i
//  REQ     | request presented, waiting for dmem_ready_i
//  RESP    | load accepted by the bus, waiting for dmem_rvalid_i
module mem_stage
    import orion_types::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  ex_mem_t          ex_mem_i,
    output logic             stall_o,
    output logic             dmem_req_o,
    input  logic             dmem_ready_i,
    output logic             dmem_we_o,
    output logic [ADDRW-1:0] dmem_addr_o,
    output logic [MASKW-1:0] dmem_wmask_o,
    output logic [XLEN-1:0]  dmem_wdata_o,
    input  logic             dmem_rvalid_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output mem_wb_t          mem_wb_o,
    output logic             misalign_o
);

    mem_state_e       state;
    mem_wb_t          wb_next;
    logic             is_ld, is_st, is_mem, mis, mem_ok;
    logic             hs, store_done, load_done, complete;
    logic [MASKW-1:0] wmask, rmask;
    logic [XLEN-1:0]  wdata, load_val;

    mem_align u_align (
        .op         (ex_mem_i.op),
        .off        (ex_mem_i.alu[1:0]),
        .store_data (ex_mem_i.store_data),
        .rdata      (dmem_rdata_i),
        .misaligned (mis),
        .wmask      (wmask),
        .rmask      (rmask),
        .wdata      (wdata),
        .load_val   (load_val)
    );

    assign is_ld  = is_load(ex_mem_i.op);
    assign is_st  = is_store(ex_mem_i.op);
    assign is_mem = is_ld | is_st;
    assign mem_ok = ex_mem_i.valid & is_mem & ~mis;

    // EX holds ex_mem_i while stalled, so the bus fields stay constant through REQ/RESP.
    assign dmem_req_o   = rst_i & (((state == ST_IDLE) & mem_ok) | (state == ST_REQ));
    assign dmem_we_o    = is_st;
    assign dmem_addr_o  = {ex_mem_i.alu[ADDRW-1:2], 2'b00};
    assign dmem_wmask_o = is_st ? wmask : '0;
    assign dmem_wdata_o = wdata;

    assign hs         = dmem_req_o & dmem_ready_i;
    assign store_done = hs & is_st;
    assign load_done  = (state == ST_RESP) & dmem_rvalid_i;

    // A misaligned op retires on its own cycle, so it never holds EX.
    assign misalign_o = rst_i & (state == ST_IDLE) & ex_mem_i.valid & is_mem & mis;
    assign stall_o    = rst_i & ex_mem_i.valid & is_mem & ~mis & ~store_done & ~load_done;
    assign complete   = ((state == ST_IDLE) & ex_mem_i.valid & (~is_mem | mis))
                      | store_done | load_done;

    always_comb begin
        wb_next       = '0;
        wb_next.valid = 1'b1;
        wb_next.rd_s  = ex_mem_i.rd_s;
        wb_next.rd_we = ex_mem_i.rd_we & ~(is_mem & mis);
        wb_next.rd_v  = (is_ld & ~mis) ? load_val : ex_mem_i.alu;
        wb_next.pc    = ex_mem_i.debug.pc;
        wb_next.insn  = ex_mem_i.debug.insn;
        if (is_mem & ~mis) begin
            wb_next.mem_addr  = ex_mem_i.alu[ADDRW-1:0];
            wb_next.mem_rmask = is_ld ? rmask : '0;
            wb_next.mem_wmask = dmem_wmask_o;
            wb_next.mem_rdata = is_ld ? dmem_rdata_i : '0;
            wb_next.mem_wdata = is_st ? dmem_wdata_o : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            mem_wb_o <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (mem_ok) begin
                        if (!hs)        state <= ST_REQ;
                        else if (is_ld) state <= ST_RESP;
                    end
                end
                ST_REQ: begin
                    if (hs) begin
                        if (is_ld) state <= ST_RESP;
                        else       state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (dmem_rvalid_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            mem_wb_o <= complete ? wb_next : '0;
        end
    end

endmodule
